// File: rtl/axi_burst_mem_slave_pkg.sv
// Shared types and helpers for the AXI-style burst memory slave.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // WRAP needs a power-of-two beat count of 2..16, i.e. len of 1, 3, 7 or 15.
  function automatic logic wrap_legal(input int unsigned len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  function automatic logic burst_illegal(input logic [1:0] burst, input int unsigned len);
    return (burst_t'(burst) == BURST_RSVD) ||
           (burst_t'(burst) == BURST_WRAP && !wrap_legal(len));
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-channel beat address generator: latches the burst descriptor and steps
// through FIXED/INCR/WRAP addresses, flagging the last beat and illegal bursts.
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [1:0]        start_burst,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] nxt_addr,
  output logic              last,
  output logic              nxt_last,
  output logic              illegal
);

  burst_t             burst_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  wrap_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      burst_q <= BURST_FIXED;
      len_q   <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      addr    <= start_addr;
      burst_q <= burst_t'(start_burst);
      len_q   <= start_len;
      cnt_q   <= '0;
    end else if (advance) begin
      addr    <= nxt_addr;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // For legal WRAP lengths, len itself is the mask of the wrapping low bits.
  assign wrap_mask = ADDR_W'(len_q);

  always_comb begin
    nxt_addr = addr;
    case (burst_q)
      BURST_INCR: nxt_addr = addr + 1'b1;
      BURST_WRAP: nxt_addr = (addr & ~wrap_mask) | ((addr + 1'b1) & wrap_mask);
      default:    nxt_addr = addr;
    endcase
  end

  assign last     = (cnt_q == len_q);
  assign nxt_last = (({1'b0, cnt_q} + 1'b1) == {1'b0, len_q});
  assign illegal  = burst_illegal(burst_q, 32'(len_q));

endmodule

// File: rtl/axi_burst_mem_slave.sv
// Burst memory slave with independent write (AW/W/B) and read (AR/R) channels
// over a word-addressed register array; errors reported as SLVERR.
module axi_burst_mem_slave
  import axi_burst_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int MEM_DEPTH = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [ID_W-1:0]     awid,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [LEN_W-1:0]    arlen,
  input  logic [ID_W-1:0]     arid,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [ID_W-1:0]     rid,
  output logic [1:0]          rresp,
  output logic                rlast
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(MEM_DEPTH);
  endfunction

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  wstate_t           wstate;
  rstate_t           rstate;
  logic [ID_W-1:0]   wr_id;
  logic              wr_err;
  logic [ADDR_W-1:0] wr_addr, wr_nxt_addr, rd_addr, rd_nxt_addr;
  logic              wr_last, wr_nxt_last, wr_illegal;
  logic              rd_last, rd_nxt_last, rd_illegal;
  logic              aw_hs, w_hs, ar_hs, r_hs;
  logic              w_beat_err, w_any_err, r0_err, rn_err;
  logic              unused_gen;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
    .clk(clk), .rst(rst), .load(aw_hs), .start_addr(awaddr), .start_burst(awburst),
    .start_len(awlen), .advance(w_hs), .addr(wr_addr), .nxt_addr(wr_nxt_addr),
    .last(wr_last), .nxt_last(wr_nxt_last), .illegal(wr_illegal)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
    .clk(clk), .rst(rst), .load(ar_hs), .start_addr(araddr), .start_burst(arburst),
    .start_len(arlen), .advance(r_hs && !rlast), .addr(rd_addr), .nxt_addr(rd_nxt_addr),
    .last(rd_last), .nxt_last(rd_nxt_last), .illegal(rd_illegal)
  );

  assign unused_gen = ^{wr_nxt_addr, wr_nxt_last, rd_addr, rd_last};

  assign w_beat_err = wr_illegal || !in_range(wr_addr);
  assign w_any_err  = w_beat_err || (wlast != wr_last);
  // Beat 0 is fetched on the AR edge itself, so its error comes from the raw request.
  assign r0_err     = burst_illegal(arburst, 32'(arlen)) || !in_range(araddr);
  assign rn_err     = rd_illegal || !in_range(rd_nxt_addr);

  always_ff @(posedge clk) begin
    if (!rst && w_hs && !w_beat_err)
      for (int b = 0; b < NUM_BYTES; b++)
        if (wstrb[b]) mem[wr_addr[MEM_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate  <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      wr_id   <= '0;
      wr_err  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (aw_hs) begin
          wr_id   <= awid;
          wr_err  <= 1'b0;
          awready <= 1'b0;
          wready  <= 1'b1;
          wstate  <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          if (w_any_err) wr_err <= 1'b1;
          // The beat counter, not wlast, closes the burst.
          if (wr_last) begin
            wready <= 1'b0;
            bvalid <= 1'b1;
            bid    <= wr_id;
            bresp  <= (wr_err || w_any_err) ? RESP_SLVERR : RESP_OKAY;
            wstate <= W_RESP;
          end
        end
        default: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          wstate  <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate  <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rid     <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: if (ar_hs) begin
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rid     <= arid;
          rlast   <= (arlen == '0);
          rdata   <= r0_err ? '0 : mem[araddr[MEM_AW-1:0]];
          rresp   <= r0_err ? RESP_SLVERR : RESP_OKAY;
          rstate  <= R_DATA;
        end
        default: if (r_hs) begin
          if (rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end else begin
            rdata <= rn_err ? '0 : mem[rd_nxt_addr[MEM_AW-1:0]];
            rresp <= rn_err ? RESP_SLVERR : RESP_OKAY;
            rlast <= rd_nxt_last;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/axi_burst_mem_slave.md
Name: axi_burst_mem_slave

Overview:
- Parametrised AXI-style burst memory slave; next generation of the fixed 8-bit, single-mode Slave.
- Independent write (AW/W/B) and read (AR/R) channels run concurrently.
- Supports FIXED, INCR and WRAP bursts, per-byte write strobes, transaction IDs, and SLVERR reporting for out-of-range or illegal bursts.
- Sits behind the Master on the shared clk domain; word-addressed register-array storage.

Parameters:
DATA_W, 8, data width in bits; multiple of 8
ADDR_W, 8, word-address width
ID_W, 4, transaction ID width
LEN_W, 4, burst length field width; beats = len+1
MEM_DEPTH, 128, implemented words; must be <= 2**ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
awvalid/awready  in/out  1  write-address handshake
awaddr  in  ADDR_W  start word address
awlen  in  LEN_W  beats-1
awid  in  ID_W  write ID
awburst  in  2  0=FIXED 1=INCR 2=WRAP 3=reserved
wvalid/wready  in/out  1  write-data handshake
wdata  in  DATA_W  beat data
wstrb  in  DATA_W/8  byte enables
wlast  in  1  master's last-beat flag
bvalid/bready  out/in  1  write-response handshake
bid  out  ID_W  echoed awid
bresp  out  2  0=OKAY 2=SLVERR
arvalid/arready  in/out  1  read-address handshake
araddr, arlen, arid, arburst  in  ADDR_W/LEN_W/ID_W/2  as AW
rvalid/rready  out/in  1  read-data handshake
rdata  out  DATA_W  beat data
rid  out  ID_W  echoed arid
rresp  out  2  per-beat response
rlast  out  1  final beat

Behaviour:
- Reset: awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bid, bresp, rid, rresp, rdata=0. Both FSMs go to IDLE. Memory contents are not cleared. Reset mid-burst abandons the burst; no response is issued.
- Handshake: a transfer occurs on a rising edge with valid&&ready. Valid outputs hold, with payload stable, until accepted.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch addr/len/id/burst; next cycle W_DATA, awready=0, wready=1.
  - W_DATA: each W handshake writes the enabled bytes at the current address and advances the address and beat counter.
  - The beat counter, not wlast, ends the burst. A wlast value that disagrees with the counter sets the sticky error flag.
  - After beat len+1: wready=0, bvalid=1 next cycle (W_RESP).
  - W_RESP: hold until bready; then W_IDLE with awready=1 the following cycle.
- Read FSM R_IDLE -> R_DATA:
  - On AR handshake: arready=0; rvalid=1 the next cycle carrying beat 0 (registered read, 1-cycle latency).
  - On each R handshake, load the next beat the next cycle with no bubble.
  - rlast=1 on beat len+1. Its handshake returns to R_IDLE: rvalid=0, arready=1.
- Address generation:
  - FIXED: address is constant.
  - INCR: +1 per beat, modulo 2**ADDR_W.
  - WRAP: legal only for beats in {2,4,8,16}. Low log2(beats) bits increment and wrap within the aligned block; upper bits are fixed.
- Errors:
  - Beat address >= MEM_DEPTH: write dropped; read returns rdata=0 with rresp=2.
  - Illegal WRAP length or burst=3: every beat errors and there is no memory access.
  - bresp=2 if any beat errored or wlast mismatched; otherwise 0.
  - rresp is per beat.
- Read/write collision on the same word in the same edge: read returns the pre-write value.

Decomposition:
- Package axi_burst_pkg holds:
  - burst_t enum (FIXED/INCR/WRAP/RSVD);
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - function wrap_legal(len).
- Sub-module axi_burst_addr_gen holds start address, burst type and len, and produces next address, last-beat flag and illegal flag. It is instantiated once per channel.

Test Plan:
1. INCR write awaddr=0x10 len=3 id=5 data 1,2,3,4 wstrb=1 -> bresp=0 bid=5. INCR read of the same range, id=5 -> rdata 1,2,3,4 with rlast on the 4th beat, rresp=0, rid=5.
2. Preload 0x04..0x07 = A,B,C,D; WRAP read araddr=0x06 len=3 -> rdata C,D,A,B (addresses 6,7,4,5); arlen=2 WRAP -> all rresp=2, rdata=0.
3. Out of range, MEM_DEPTH=128:
   - INCR write 0x7F len=1 data 9,8 -> bresp=2, word 0x7F=9;
   - read 0x7F len=1 -> rdata 9,0, rresp 0,2.
4. Backpressure:
   - rready low 3 cycles after beat 2 -> rdata/rlast/rid stable, no beat skipped;
   - bready low 5 cycles -> bvalid and bresp held;
   - wvalid gaps -> bursts still complete.
5. Write len=3 with wlast asserted on beat 2 -> all 4 beats accepted and written, bresp=2. Same-edge write and read of word 0x20 -> read returns the old value.
6. Reset asserted mid read burst, then mid write burst -> next cycle rvalid=0, wready=0, arready=awready=1, no bvalid. A re-read returns previously written data.
